// File: rtl/fastbconv_q_to_bba_seq.sv
// -----------------------------------------------------------------------------
// fastbconv_q_to_bba_seq
//
// Sequential fast base extension from the q basis to the B u Ba basis.
// For every slot k and every output prime p_j it computes
//
//   out[k][j] = ( sum_i [x[k][i] * qhat_inv_i mod q_i] * (qhat_i mod p_j) ) mod p_j
//
// which is the approximate lift x + alpha*Q with 0 <= alpha < IN_BASIS_LEN.
// No correction of alpha is applied.
//
// Scheduling:
// - All slots are processed in parallel.
// - The q residues are folded in one per cycle through a single
//   multiply/reduce lane per (slot, output prime).
// - One job is in flight at a time, with no skid path.
// - From the input handshake cycle, out_valid is seen IN_BASIS_LEN+2 cycles
//   later.
// - With out_ready held high, a new job starts every IN_BASIS_LEN+3 cycles.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   in_valid        input_RNSpoly is valid
//   in_ready        block can accept a job (high only in IDLE)
//   input_RNSpoly   [N_SLOTS][IN_BASIS_LEN] residues, each < q_i
//   out_valid       output_RNSpoly is valid (held until out_ready)
//   out_ready       consumer accepts the output
//   output_RNSpoly  [N_SLOTS][OUT_BASIS_LEN] residues, each < p_j, registered
// -----------------------------------------------------------------------------
module fastbconv_q_to_bba_seq #(
  parameter int N_SLOTS       = 2,
  parameter int IN_BASIS_LEN  = 2,
  parameter int OUT_BASIS_LEN = 3,
  parameter int PRIME_BITS    = 5,
  parameter int IN_BASIS       [IN_BASIS_LEN]                = '{17, 19},
  parameter int OUT_BASIS      [OUT_BASIS_LEN]               = '{23, 29, 31},
  parameter int QHAT_INV_MOD_Q [IN_BASIS_LEN]                = '{9, 9},
  parameter int QHAT_MOD_OUT   [IN_BASIS_LEN][OUT_BASIS_LEN] = '{'{19, 19, 19},
                                                                 '{17, 17, 17}}
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic [N_SLOTS-1:0][IN_BASIS_LEN-1:0][PRIME_BITS-1:0]  input_RNSpoly,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [N_SLOTS-1:0][OUT_BASIS_LEN-1:0][PRIME_BITS-1:0] output_RNSpoly
);

  localparam int W     = PRIME_BITS;
  localparam int W2    = 2 * PRIME_BITS;
  localparam int CNT_W = (IN_BASIS_LEN > 1) ? $clog2(IN_BASIS_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IN_BASIS_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg;
  logic   in_ready_reg;
  logic   out_valid_reg;
  logic [CNT_W-1:0] i_cnt_reg;

  // Captured input residues, scaled residues y, and accumulators.
  logic [N_SLOTS-1:0][IN_BASIS_LEN-1:0][W-1:0]  x_reg;
  logic [N_SLOTS-1:0][IN_BASIS_LEN-1:0][W-1:0]  y_reg;
  logic [N_SLOTS-1:0][IN_BASIS_LEN-1:0][W-1:0]  y_next;
  logic [N_SLOTS-1:0][OUT_BASIS_LEN-1:0][W-1:0] acc_reg;
  logic [N_SLOTS-1:0][OUT_BASIS_LEN-1:0][W-1:0] acc_next;
  logic [N_SLOTS-1:0][OUT_BASIS_LEN-1:0][W-1:0] out_reg;

  // Operands of the current fold step, selected by i_cnt.
  logic [N_SLOTS-1:0][W-1:0]       y_sel;
  logic [OUT_BASIS_LEN-1:0][W-1:0] q_sel;

  assign in_ready       = in_ready_reg;
  assign out_valid      = out_valid_reg;
  assign output_RNSpoly = out_reg;

  // ---------------------------------------------------------------------------
  // Scale stage: y[k][i] = x[k][i] * qhat_inv_i mod q_i.
  // The product is kept at full 2W width before reduction.
  // ---------------------------------------------------------------------------
  genvar gk, gi, gj;
  generate
    for (gk = 0; gk < N_SLOTS; gk++) begin : g_scale_slot
      for (gi = 0; gi < IN_BASIS_LEN; gi++) begin : g_scale_res
        logic [W2-1:0] prod;
        assign prod = W2'(x_reg[gk][gi]) * W2'(QHAT_INV_MOD_Q[gi]);
        assign y_next[gk][gi] = W'(prod % W2'(IN_BASIS[gi]));
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Operand selection for the fold step.
  // - Explicit compare-and-pick loops keep the selects in range for any
  //   IN_BASIS_LEN, including non-powers of two.
  // - The qhat-mod-p constants form a small ROM indexed by i_cnt.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < N_SLOTS; k++) begin
      y_sel[k] = '0;
      for (int i = 0; i < IN_BASIS_LEN; i++) begin
        if (i_cnt_reg == CNT_W'(i)) begin
          y_sel[k] = y_reg[k][i];
        end
      end
    end
    for (int j = 0; j < OUT_BASIS_LEN; j++) begin
      q_sel[j] = '0;
      for (int i = 0; i < IN_BASIS_LEN; i++) begin
        if (i_cnt_reg == CNT_W'(i)) begin
          q_sel[j] = W'(QHAT_MOD_OUT[i][j]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fold step: acc = (acc + y_i * qhat_i_mod_p) mod p, per slot and per prime.
  // - acc < p and the product < 2^(2W), so the sum fits in 2W+1 bits.
  // - Reducing every cycle keeps acc < p_j, even for out-of-range inputs.
  // ---------------------------------------------------------------------------
  generate
    for (gk = 0; gk < N_SLOTS; gk++) begin : g_acc_slot
      for (gj = 0; gj < OUT_BASIS_LEN; gj++) begin : g_acc_prime
        logic [W2-1:0] prod;
        logic [W2:0]   sum;
        assign prod = W2'(y_sel[gk]) * W2'(q_sel[gj]);
        assign sum  = {1'b0, prod} + (W2+1)'(acc_reg[gk][gj]);
        assign acc_next[gk][gj] = W'(sum % (W2+1)'(OUT_BASIS[gj]));
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control FSM.
  // - All handshake outputs are registered.
  // - in_ready is raised on the same edge that completes the output
  //   handshake.
  // - A new job can therefore be accepted one cycle after the transfer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      i_cnt_reg     <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      acc_reg       <= '0;
      out_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            x_reg        <= input_RNSpoly;
            in_ready_reg <= 1'b0;
            state_reg    <= SCALE;
          end
        end

        SCALE: begin
          y_reg     <= y_next;
          acc_reg   <= '0;
          i_cnt_reg <= '0;
          state_reg <= ACCUM;
        end

        ACCUM: begin
          acc_reg <= acc_next;
          if (i_cnt_reg == LAST_IDX) begin
            // The last fold result goes straight to the output register,
            // so DONE begins with valid data.
            out_reg       <= acc_next;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            i_cnt_reg <= i_cnt_reg + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fastbconv_q_to_bba_seq.sv
// -----------------------------------------------------------------------------
// Directed bench for fastbconv_q_to_bba_seq in its default configuration:
//   q = {17, 19}, B u Ba = {23, 29, 31}.
// Hand-computed vectors cover:
//   - latency and back-pressure,
//   - back-to-back throughput,
//   - abort on reset.
// A run of random jobs is checked against an arithmetic model.
// The model derives qhat and its inverse from the primes themselves.
// -----------------------------------------------------------------------------
module tb_fastbconv_q_to_bba_seq;

  localparam int NS = 2;
  localparam int IL = 2;
  localparam int OL = 3;
  localparam int W  = 5;

  logic clk;
  logic reset;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic [NS-1:0][IL-1:0][W-1:0] input_RNSpoly;
  logic [NS-1:0][OL-1:0][W-1:0] output_RNSpoly;

  int vectors     = 0;
  int miscompares = 0;

  fastbconv_q_to_bba_seq dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .input_RNSpoly  (input_RNSpoly),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .output_RNSpoly (output_RNSpoly)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Packs three per-prime residues of one slot, prime 0 in the low bits.
  function automatic logic [31:0] mk3(input int e0, input int e1, input int e2);
    logic [14:0] v;
    v = {5'(e2), 5'(e1), 5'(e0)};
    return 32'(v);
  endfunction

  function automatic logic [31:0] slot_of(input int k);
    return 32'(output_RNSpoly[k]);
  endfunction

  // Reference: sum over i of ((r_i*qhat_inv_i) mod q_i) * qhat_i,
  // then reduced mod each p_j.
  function automatic logic [31:0] model(input int r0, input int r1);
    int q [2];
    int p [3];
    int big_q;
    int qhat [2];
    int inv  [2];
    int r    [2];
    int v;
    int e    [3];
    q = '{17, 19};
    p = '{23, 29, 31};
    r[0] = r0;
    r[1] = r1;
    big_q = q[0] * q[1];
    v = 0;
    for (int i = 0; i < 2; i++) begin
      qhat[i] = big_q / q[i];
      inv[i]  = 0;
      for (int c = 1; c < q[i]; c++) begin
        if (((qhat[i] % q[i]) * c) % q[i] == 1) inv[i] = c;
      end
      v += ((r[i] * inv[i]) % q[i]) * qhat[i];
    end
    for (int j = 0; j < 3; j++) e[j] = v % p[j];
    return mk3(e[0], e[1], e[2]);
  endfunction

  // Offers one job (slot0 = {a0,a1}, slot1 = {b0,b1}) and returns just after
  // the handshake edge.
  task automatic send(input int a0, input int a1, input int b0, input int b1);
    int n;
    input_RNSpoly[0][0] = 5'(a0);
    input_RNSpoly[0][1] = 5'(a1);
    input_RNSpoly[1][0] = 5'(b0);
    input_RNSpoly[1][1] = 5'(b1);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Waits for out_valid.
  // n = number of edges after the handshake edge before out_valid is seen.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
    check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic accept_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [NS-1:0][OL-1:0][W-1:0] o1;
  logic [NS-1:0][OL-1:0][W-1:0] o2;

  initial begin
    int n;
    int t1;
    int t2;
    int seen;
    int cyc;
    int r [NS][IL];
    logic [31:0] exp_slot [NS];
    int p [3];
    bit  done;

    p = '{23, 29, 31};
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    input_RNSpoly = '0;
    o1 = '0;
    o2 = '0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_output", 32'(output_RNSpoly), 32'd0);
    reset = 1'b1;
    tick();

    // ---------------- x=100 and {1,1}, latency, back-pressure ----------------
    send(15, 5, 1, 1);
    check("busy_in_ready", 32'(in_ready), 32'd0);
    wait_out(n);
    check("latency", 32'(n + 1), 32'd4);
    check("x100_slot0", slot_of(0), mk3(9, 17, 20));
    check("one_one_slot1", slot_of(1), mk3(2, 5, 14));
    $display("job x100: slot0=%h slot1=%h", output_RNSpoly[0], output_RNSpoly[1]);
    for (int i = 0; i < 5; i++) begin
      // Wiggle in_valid with a different input while busy; it must be ignored.
      in_valid = (i % 2) == 1;
      input_RNSpoly = '0;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_stable", slot_of(0), mk3(9, 17, 20));
      tick();
    end
    in_valid = 1'b0;
    check("bp_stable_end", slot_of(0), mk3(9, 17, 20));
    accept_out();
    check("xfer_out_valid", 32'(out_valid), 32'd0);
    check("xfer_in_ready", 32'(in_ready), 32'd1);

    // ---------------- zeros in one slot ----------------
    send(0, 0, 15, 5);
    wait_out(n);
    check("zero_slot0", slot_of(0), 32'd0);
    check("zero_x100_slot1", slot_of(1), mk3(9, 17, 20));
    $display("job zero: slot0=%h slot1=%h", output_RNSpoly[0], output_RNSpoly[1]);
    accept_out();

    // ---------------- back-to-back ----------------
    check("b2b_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    input_RNSpoly[0][0] = 5'd15;
    input_RNSpoly[0][1] = 5'd5;
    input_RNSpoly[1][0] = 5'd1;
    input_RNSpoly[1][1] = 5'd1;
    in_valid = 1'b1;
    seen = 0;
    t1 = 0;
    t2 = 0;
    cyc = 0;
    while (seen < 2 && cyc < 40) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        input_RNSpoly[0][0] = 5'd1;
        input_RNSpoly[0][1] = 5'd1;
        input_RNSpoly[1][0] = 5'd0;
        input_RNSpoly[1][1] = 5'd0;
      end
      if (out_valid) begin
        if (seen == 0) begin
          t1 = cyc;
          o1 = output_RNSpoly;
        end else begin
          t2 = cyc;
          o2 = output_RNSpoly;
          in_valid = 1'b0;
        end
        seen++;
      end
    end
    check("b2b_count", 32'(seen), 32'd2);
    check("b2b_first_latency", 32'(t1), 32'd4);
    check("b2b_spacing", 32'(t2 - t1), 32'd5);
    check("b2b_o1_slot0", 32'(o1[0]), mk3(9, 17, 20));
    check("b2b_o1_slot1", 32'(o1[1]), mk3(2, 5, 14));
    check("b2b_o2_slot0", 32'(o2[0]), mk3(2, 5, 14));
    check("b2b_o2_slot1", 32'(o2[1]), 32'd0);
    $display("job b2b: first=%h second=%h spacing=%0d", o1, o2, t2 - t1);
    tick();
    out_ready = 1'b0;
    tick();

    // ---------------- reset during ACCUM ----------------
    send(15, 5, 15, 5);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_output", 32'(output_RNSpoly), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_no_out", 32'(out_valid), 32'd0);
    send(1, 1, 0, 0);
    wait_out(n);
    check("post_rst_latency", 32'(n + 1), 32'd4);
    check("post_rst_slot0", slot_of(0), mk3(2, 5, 14));
    check("post_rst_slot1", slot_of(1), 32'd0);
    $display("job after abort: slot0=%h slot1=%h", output_RNSpoly[0], output_RNSpoly[1]);
    accept_out();

    // ---------------- out-of-contract residues stay reduced ----------------
    send(31, 31, 31, 20);
    wait_out(n);
    for (int k = 0; k < NS; k++) begin
      for (int j = 0; j < OL; j++) begin
        check("ooc_range", 32'(int'(output_RNSpoly[k][j]) < p[j]), 32'd1);
      end
    end
    $display("job ooc: slot0=%h slot1=%h", output_RNSpoly[0], output_RNSpoly[1]);
    accept_out();

    // ---------------- random jobs with random stalls ----------------
    for (int job = 0; job < 1000; job++) begin
      for (int k = 0; k < NS; k++) begin
        r[k][0] = int'($urandom_range(16, 0));
        r[k][1] = int'($urandom_range(18, 0));
        exp_slot[k] = model(r[k][0], r[k][1]);
      end
      send(r[0][0], r[0][1], r[1][0], r[1][1]);
      done = 1'b0;
      n = 0;
      while (!done && n < 200) begin
        if (out_valid) begin
          out_ready = ($urandom_range(3, 0) != 0);
          if (out_ready) done = 1'b1;
        end
        if (!done) begin
          tick();
          n++;
        end
      end
      check("rand_timeout", 32'(done), 32'd1);
      for (int k = 0; k < NS; k++) begin
        check("rand_slot", slot_of(k), exp_slot[k]);
        for (int j = 0; j < OL; j++) begin
          check("rand_range", 32'(int'(output_RNSpoly[k][j]) < p[j]), 32'd1);
        end
      end
      $display("rand job %0d: in=%h out=%h", job, input_RNSpoly, output_RNSpoly);
      tick();
      out_ready = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
